// File: rtl/irq_controller.sv
// irq_controller: memory-mapped interrupt controller with per-source edge/level capture and a
// registered lowest-index-wins CPU request. Define IRQ_CONTROLLER_SYNC2_EN for a two-flop synchroniser.

module irq_source #(
    parameter int SYNC_STAGES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    input  logic edge_mode,
    input  logic w1c,
    output logic sync,
    output logic pending
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            prev    <= 1'b0;
            pending <= 1'b0;
        end else begin
            sync_q[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev <= sync;
            // Edge capture: a fresh rising edge beats a simultaneous W1C.
            if (edge_mode) pending <= (pending & ~w1c) | (sync & ~prev);
            else           pending <= sync;
        end
    end
endmodule

module irq_controller #(
    parameter logic [7:0] ID        = 8'h04,
    parameter int         IRQ_COUNT = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 peripheralBus_we,
    input  logic                 peripheralBus_oe,
    output logic                 peripheralBus_busy,
    input  logic [23:0]          peripheralBus_address,
    input  logic [3:0]           peripheralBus_byteSelect,
    output logic [31:0]          peripheralBus_dataRead,
    input  logic [31:0]          peripheralBus_dataWrite,
    output logic                 requestOutput,
    input  logic [IRQ_COUNT-1:0] irq_in,
    output logic                 irq_out,
    output logic [3:0]           irq_id
);
`ifdef IRQ_CONTROLLER_SYNC2_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 1;
`endif

    localparam logic [11:0] OFF_PENDING = 12'h000;
    localparam logic [11:0] OFF_ENABLE  = 12'h004;
    localparam logic [11:0] OFF_EDGE    = 12'h008;
    localparam logic [11:0] OFF_ACTIVE  = 12'h00C;
    localparam logic [11:0] OFF_RAW     = 12'h010;

    logic                 selected, wr;
    logic [11:0]          offset;
    logic [15:0]          byte_mask;
    logic [IRQ_COUNT-1:0] wmask, wdata, w1c, pending, sync, enable_q, edge_q, active;
    logic [3:0]           id_nxt;
    logic [31:0]          rdata;
    logic                 unused_ok;

    assign selected           = peripheralBus_address[23:12] == {4'h0, ID};
    assign offset             = {peripheralBus_address[11:2], 2'b00};
    assign wr                 = peripheralBus_we & selected;
    assign requestOutput      = selected & peripheralBus_oe;
    assign peripheralBus_busy = 1'b0;

    // Only the low two byte lanes carry source bits.
    assign byte_mask = {{8{peripheralBus_byteSelect[1]}}, {8{peripheralBus_byteSelect[0]}}};
    assign wmask     = byte_mask[IRQ_COUNT-1:0];
    assign wdata     = peripheralBus_dataWrite[IRQ_COUNT-1:0] & wmask;
    assign w1c       = (wr && offset == OFF_PENDING) ? wdata : '0;
    assign unused_ok = ^{peripheralBus_dataWrite, peripheralBus_byteSelect,
                         peripheralBus_address[1:0], byte_mask};

    for (genvar gi = 0; gi < IRQ_COUNT; gi++) begin : g_src
        irq_source #(.SYNC_STAGES(SYNC_STAGES)) u_src (
            .clk      (clk),
            .rst      (rst),
            .irq_in   (irq_in[gi]),
            .edge_mode(edge_q[gi]),
            .w1c      (w1c[gi]),
            .sync     (sync[gi]),
            .pending  (pending[gi])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_q <= '0;
            edge_q   <= '1;
        end else if (wr) begin
            if (offset == OFF_ENABLE) enable_q <= (enable_q & ~wmask) | wdata;
            if (offset == OFF_EDGE)   edge_q   <= (edge_q & ~wmask) | wdata;
        end
    end

    assign active = pending & enable_q;

    // Scan downwards so the lowest active index is the last (winning) assignment.
    always_comb begin
        id_nxt = '0;
        for (int i = IRQ_COUNT - 1; i >= 0; i--)
            if (active[i]) id_nxt = 4'(i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_out <= 1'b0;
            irq_id  <= '0;
        end else begin
            irq_out <= |active;
            irq_id  <= id_nxt;
        end
    end

    always_comb begin
        rdata = '0;
        case (offset)
            OFF_PENDING: rdata = 32'(pending);
            OFF_ENABLE:  rdata = 32'(enable_q);
            OFF_EDGE:    rdata = 32'(edge_q);
            OFF_ACTIVE:  rdata = {irq_out, 27'b0, irq_id};
            OFF_RAW:     rdata = 32'(sync);
            default:     rdata = '0;
        endcase
    end

    assign peripheralBus_dataRead = requestOutput ? rdata : '0;
endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus random traffic against a history-based model.
module tb_irq_controller;
    localparam int IRQ = 10;
`ifdef IRQ_CONTROLLER_SYNC2_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif
    localparam logic [15:0] MASK = 16'h03FF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0, oe = 1'b0, busy, req;
    logic [23:0] address = '0;
    logic [3:0]  bs = '0;
    logic [31:0] rdata, wdata = '0;
    logic [IRQ-1:0] irq_in = '0;
    logic        irq_out;
    logic [3:0]  irq_id;

    irq_controller #(.ID(8'h04), .IRQ_COUNT(IRQ)) dut (
        .clk(clk), .rst(rst),
        .peripheralBus_we(we), .peripheralBus_oe(oe), .peripheralBus_busy(busy),
        .peripheralBus_address(address), .peripheralBus_byteSelect(bs),
        .peripheralBus_dataRead(rdata), .peripheralBus_dataWrite(wdata),
        .requestOutput(req), .irq_in(irq_in), .irq_out(irq_out), .irq_id(irq_id)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Reference state: registers as the spec describes them, plus the input sample history.
    logic [15:0] m_pend, m_en, m_edg;
    logic        m_out;
    logic [3:0]  m_id;
    int          n;
    logic [15:0] samp [0:8191];

    function automatic logic [15:0] sync_after(int k);
        if (k - L + 1 >= 1) return samp[k-L+1];
        return 16'h0;
    endfunction

    function automatic logic [3:0] lowest(logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
        return 4'h0;
    endfunction

    function automatic logic [31:0] model_read(logic [11:0] off);
        case (off)
            12'h000: return {16'h0, m_pend};
            12'h004: return {16'h0, m_en};
            12'h008: return {16'h0, m_edg};
            12'h00C: return {m_out, 27'b0, m_id};
            12'h010: return {16'h0, sync_after(n)};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = 0; m_en = 0; m_edg = MASK; m_out = 0; m_id = 0; n = 0;
    endtask

    task automatic model_step();
        logic [15:0] cur, prv, rise, act, wm, wd, w1c;
        logic [11:0] off;
        logic        wr;
        cur  = sync_after(n);
        prv  = sync_after(n - 1);
        rise = cur & ~prv;
        act  = m_pend & m_en;
        m_out = (act != 0);
        m_id  = lowest(act);
        wr   = we && (address[23:12] == 12'h004);
        off  = {address[11:2], 2'b00};
        wm   = {{8{bs[1]}}, {8{bs[0]}}} & MASK;
        wd   = wdata[15:0] & wm;
        w1c  = (wr && off == 12'h000) ? wd : 16'h0;
        for (int i = 0; i < IRQ; i++) begin
            if (m_edg[i]) begin
                if (rise[i]) m_pend[i] = 1'b1;
                else if (w1c[i]) m_pend[i] = 1'b0;
            end else begin
                m_pend[i] = cur[i];
            end
        end
        if (wr && off == 12'h004) m_en  = (m_en & ~wm) | wd;
        if (wr && off == 12'h008) m_edg = (m_edg & ~wm) | wd;
        n++;
        samp[n] = 16'(irq_in);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("irq_out", 32'(irq_out), 32'(m_out));
        chk("irq_id", 32'(irq_id), 32'(m_id));
        chk("busy", 32'(busy), 32'h0);
    endtask

    task automatic wr(input logic [11:0] off, input logic [31:0] d, input logic [3:0] b);
        address = {12'h004, off[11:2], 2'($urandom)};
        wdata = d; bs = b; we = 1'b1;
        cyc();
        we = 1'b0;
    endtask

    task automatic rd(input logic [11:0] off, input string tag, output logic [31:0] v);
        address = {12'h004, off[11:2], 2'($urandom)};
        oe = 1'b1;
        #1;
        chk({tag, "_req"}, 32'(req), 32'h1);
        chk(tag, rdata, model_read(off));
        v = rdata;
        oe = 1'b0;
    endtask

    logic [11:0] offtab [8] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h020, 12'hFFC};
    logic [31:0] v;

    initial begin
        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_irq_out", 32'(irq_out), 32'h0);
        chk("rst_irq_id", 32'(irq_id), 32'h0);
        rd(12'h000, "rst_pending", v); chk("rst_pending_c", v, 32'h0);
        rd(12'h004, "rst_enable", v);  chk("rst_enable_c", v, 32'h0);
        rd(12'h008, "rst_edge", v);    chk("rst_edge_c", v, 32'h3FF);
        @(negedge clk) rst = 1'b1;

        // Single-cycle pulse on source 0 reaches irq_out after sync latency + 2 edges
        wr(12'h004, 32'h1, 4'b0011);
        irq_in[0] = 1'b1;
        cyc();
        irq_in[0] = 1'b0;
        for (int k = 2; k <= L + 2; k++) begin
            cyc();
            chk("pulse_lat", 32'(irq_out), (k == L + 2) ? 32'h1 : 32'h0);
        end
        chk("pulse_id", 32'(irq_id), 32'h0);
        rd(12'h000, "pulse_pend", v); chk("pulse_pend_c", v, 32'h1);

        // W1C clears, then W1C colliding with a new rising edge loses
        wr(12'h000, 32'h1, 4'b0001);
        cyc();
        chk("w1c_out", 32'(irq_out), 32'h0);
        irq_in[0] = 1'b1;
        repeat (L) cyc();
        wr(12'h000, 32'h1, 4'b0001);
        rd(12'h000, "set_wins", v); chk("set_wins_c", v, 32'h1);
        irq_in[0] = 1'b0;
        repeat (2) cyc();
        wr(12'h000, 32'h1, 4'b0001);
        cyc();

        // Priority: lowest index wins
        wr(12'h004, 32'h3FF, 4'b0011);
        irq_in = 10'h210;
        repeat (L + 2) cyc();
        chk("prio_id4", 32'(irq_id), 32'h4);
        rd(12'h00C, "active", v); chk("active_c", v, 32'h8000_0004);
        wr(12'h000, 32'h10, 4'b0001);
        cyc();
        chk("prio_id9", 32'(irq_id), 32'h9);
        irq_in = '0;
        wr(12'h000, 32'h200, 4'b0011);
        cyc();

        // Level mode follows the input and ignores W1C
        wr(12'h008, 32'h0, 4'b0011);
        irq_in[2] = 1'b1;
        repeat (L + 1) cyc();
        rd(12'h000, "lvl_hi", v); chk("lvl_hi_c", v, 32'h4);
        wr(12'h000, 32'h4, 4'b0001);
        rd(12'h000, "lvl_w1c", v); chk("lvl_w1c_c", v, 32'h4);
        irq_in[2] = 1'b0;
        repeat (L + 1) cyc();
        rd(12'h000, "lvl_lo", v); chk("lvl_lo_c", v, 32'h0);
        wr(12'h008, 32'h3FF, 4'b0011);

        // Byte enables, unmapped offset, foreign select ID
        wr(12'h004, 32'h0, 4'b0011);
        wr(12'h004, 32'hFFFF, 4'b0010);
        rd(12'h004, "bytesel", v); chk("bytesel_c", v, 32'h300);
        rd(12'h020, "unmapped", v); chk("unmapped_c", v, 32'h0);
        address = 24'h005004; oe = 1'b1;
        #1;
        chk("foreign_req", 32'(req), 32'h0);
        oe = 1'b0;

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            int r;
            if ($urandom_range(0, 3) == 0) irq_in = IRQ'($urandom);
            r = $urandom_range(0, 7);
            if (r == 0) begin
                logic [11:0] off;
                off = offtab[$urandom_range(0, 7)];
                address = {4'h0, ($urandom_range(0, 7) == 0) ? 8'h05 : 8'h04, off[11:2], 2'($urandom)};
                wdata = $urandom; bs = 4'($urandom); we = 1'b1;
                cyc();
                we = 1'b0;
            end else if (r == 1) begin
                rd(offtab[$urandom_range(0, 7)], "rnd_rd", v);
                cyc();
            end else begin
                cyc();
            end
        end

        // Asynchronous reset while an interrupt is being signalled
        irq_in = '0;
        wr(12'h004, 32'h1, 4'b0011);
        wr(12'h008, 32'h3FF, 4'b0011);
        repeat (L + 2) cyc();
        wr(12'h000, 32'h3FF, 4'b0011);
        cyc();
        irq_in[0] = 1'b1;
        cyc();
        irq_in[0] = 1'b0;
        repeat (L + 1) cyc();
        chk("pre_rst_out", 32'(irq_out), 32'h1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_out", 32'(irq_out), 32'h0);
        chk("async_id", 32'(irq_id), 32'h0);
        rd(12'h000, "async_pend", v); chk("async_pend_c", v, 32'h0);
        rd(12'h004, "async_en", v);   chk("async_en_c", v, 32'h0);
        rd(12'h008, "async_edge", v); chk("async_edge_c", v, 32'h3FF);
        rd(12'h010, "async_raw", v);  chk("async_raw_c", v, 32'h0);
        irq_in[0] = 1'b1;
        @(negedge clk) rst = 1'b1;
        repeat (L + 1) cyc();
        rd(12'h000, "rel_edge", v); chk("rel_edge_c", v, 32'h1);
        wr(12'h000, 32'h1, 4'b0001);
        repeat (3) cyc();
        rd(12'h000, "rel_once", v); chk("rel_once_c", v, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
